fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the program counter and the instruction-fetch handshake at the front of the RISC-V core.
- Selects the next PC from three sources: sequential (+4), branch/jump redirect, or trap vector.
- Issues one instruction-memory request at a time and delivers fetched instructions to decode with valid/ready flow control.
- Discards stale responses after a redirect; the PC register lives inside this block.

Parameters:
- XLEN, 32, width of PC and address paths.
- RESET_VECTOR, 32'h8000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  single core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  branch/jump target.
- trap_valid  in  1  trap/exception taken this cycle.
- trap_vector  in  XLEN  trap target (mtvec).
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address; always equals current_pc.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid; exactly one per accepted request.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_pc  out  XLEN  PC of the delivered instruction.
- if_instr  out  32  delivered instruction.
- if_ready  in  1  decode accepts the instruction.
- current_pc  out  XLEN  architectural fetch PC.
- fetch_fault  out  1  misaligned-target pulse (MISALIGN_CHECK_EN only; tied 0 otherwise).

Behaviour:
- Reset (any time, async): current_pc=RESET_VECTOR, state=BOOT. imem_req_valid, if_valid and fetch_fault are 0; if_pc=0, if_instr=0. Any in-flight transaction is abandoned; the memory side must also be reset.
- States: BOOT, REQ, WAIT, HOLD, FLUSH. At most one request is outstanding.
- BOOT: lasts one cycle after reset deassertion, then moves to REQ. No request is issued.
- REQ: imem_req_valid=1 with imem_req_addr=current_pc. A handshake (valid & ready) moves to WAIT.
- WAIT: when imem_rsp_valid is seen:
  - if_valid=1 combinationally with if_pc=current_pc and if_instr=imem_rsp_data.
  - If if_ready is also 1: current_pc += PC_STEP and go to REQ.
  - Otherwise capture the instruction and go to HOLD.
- HOLD: if_valid=1 with registered pc/instr. When if_ready=1: current_pc += PC_STEP and go to REQ.
- Redirect target selection: the target is trap_vector if trap_valid=1, else redirect_pc. trap_valid wins when both are asserted.
- Redirect handling by state:
  - REQ, ready=0: current_pc <= target; stay in REQ. Address changes while not yet accepted are permitted.
  - REQ, ready=1: the old request is accepted; current_pc <= target; go to FLUSH.
  - WAIT, rsp_valid=0: current_pc <= target; go to FLUSH.
  - WAIT, rsp_valid=1: the response is dropped and if_valid is forced to 0; current_pc <= target; go to REQ.
  - HOLD: the held instruction is dropped and if_valid is 0 from the next cycle; current_pc <= target; go to REQ.
  - FLUSH: current_pc <= target; stay in FLUSH.
  - BOOT: current_pc <= target.
- FLUSH: wait for imem_rsp_valid, discard it (if_valid=0), then go to REQ.
- Redirect inputs are single-cycle and are not queued.
- Arithmetic: PC increment is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- Throughput: one instruction per 2 cycles minimum (REQ then WAIT with a 1-cycle memory).
- Latency: redirect-to-request is 1 cycle.

Optional Feature:
- Macro: FETCH_SEQ_MISALIGN_CHECK_EN.
- Defined: a target with target[1:0]!=0 is not taken. current_pc and state are unchanged, and fetch_fault pulses for exactly 1 cycle.
- Undefined: target[1:0] is forced to 2'b00 before loading, and fetch_fault is constant 0.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (BOOT/REQ/WAIT/HOLD/FLUSH);
  - RESET_VECTOR_DEFAULT=32'h8000_0000;
  - PC_STEP_DEFAULT=4;
  - the XLEN default.
- Sub-module fetch_hold_buf: registered pc/instr holding stage with load/clear/valid, used in the HOLD state.

Test Plan:
- Reset then idle memory (ready=1, 1-cycle response, if_ready=1) -> first imem_req_addr=32'h8000_0000 two cycles after reset release; subsequent addresses 0x80000004, 0x80000008.
- if_ready=0 for 3 cycles with response 32'h00000013 at pc 0x80000000 -> if_valid held with if_instr=32'h13 for 3 cycles; no new request; pc advances only after if_ready=1.
- redirect_valid=1, redirect_pc=0x80000100 in WAIT -> following response discarded (if_valid=0); next request addr=0x80000100.
- Simultaneous trap_valid (vector 0x80000040) and redirect (0x80000100) -> next fetch addr=0x80000040.
- Async reset asserted mid-WAIT -> outputs zeroed immediately; fetch restarts at 0x80000000.
- Redirect to 0x80000102: with FETCH_SEQ_MISALIGN_CHECK_EN, fetch_fault=1 for 1 cycle and pc is unchanged; without it, next fetch addr=0x80000100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   - fetch_state_e        : sequencer FSM states
//   - XLEN_DEFAULT         : default PC / address width
//   - RESET_VECTOR_DEFAULT : default PC after reset
//   - PC_STEP_DEFAULT      : default sequential PC increment
//   - misaligned()         : true when a fetch target is not word aligned
package fetch_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;
  localparam int          PC_STEP_DEFAULT      = 4;

  typedef enum logic [2:0] {
    ST_BOOT,   // one idle cycle after reset release
    ST_REQ,    // request presented to instruction memory
    ST_WAIT,   // request accepted, waiting for the response
    ST_HOLD,   // response captured, decode is stalling
    ST_FLUSH   // drain the response of a request made stale by a redirect
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory and decode handshakes of the fetch
// sequencer.
//   imem_req_valid/addr/ready : fetch request (sequencer -> memory)
//   imem_rsp_valid/data       : fetch response (memory -> sequencer)
//   if_valid/pc/instr/ready   : delivered instruction (sequencer -> decode)
// Modports:
//   master : the fetch sequencer
//   slave  : memory + decode side
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: registered pc/instruction stage that keeps a fetched
// instruction while decode is not ready.
//   clk, reset      : clock, async active-low reset
//   load            : capture pc_in/instr_in and set valid
//   clear           : drop the held entry (wins over load)
//   pc_in, instr_in : entry to capture
//   valid, pc, instr: held entry; pc/instr read 0 when empty
module fetch_hold_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_in;
      instr <= instr_in;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and instruction-fetch handshake.
// Picks the next PC (sequential, branch/jump redirect, trap vector), keeps at
// most one instruction-memory request outstanding and hands fetched
// instructions to decode with valid/ready. Responses belonging to a request
// made stale by a redirect are drained and dropped.
//   clk, reset                 : clock, async active-low reset
//   redirect_valid/redirect_pc : branch/jump taken this cycle + target
//   trap_valid/trap_vector     : trap taken this cycle + target (wins)
//   bus (master)               : imem request/response and decode handshake
//   current_pc                 : architectural fetch PC (== imem_req_addr)
//   fetch_fault                : misaligned-target pulse
// Build option FETCH_SEQ_MISALIGN_CHECK_EN: when defined, a target with
// nonzero low two bits is refused and fetch_fault pulses for one cycle; when
// undefined, the low two bits of a target are cleared and fetch_fault is 0.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              PC_STEP      = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vector,
  fetch_sequencer_if.master bus,
  output logic [XLEN-1:0]   current_pc,
  output logic              fetch_fault
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;

  logic            redir_req;
  logic            take;
  logic [XLEN-1:0] tgt_sel;
  logic [XLEN-1:0] tgt;

  logic            rsp_deliver;
  logic            hb_load;
  logic            hb_clear;
  logic            hb_valid;
  logic [XLEN-1:0] hb_pc;
  logic [31:0]     hb_instr;

  assign redir_req = redirect_valid | trap_valid;
  assign tgt_sel   = trap_valid ? trap_vector : redirect_pc;

`ifdef FETCH_SEQ_MISALIGN_CHECK_EN
  logic fault_q;

  assign tgt  = tgt_sel;
  assign take = redir_req & ~misaligned(tgt_sel[1:0]);

  // A refused redirect leaves pc/state alone; only the fault pulse records it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= redir_req & ~take;
  end

  assign fetch_fault = fault_q;
`else
  assign tgt         = tgt_sel & ~XLEN'(3);
  assign take        = redir_req;
  assign fetch_fault = 1'b0;
`endif

  // A response arriving together with a redirect belongs to the old path.
  assign rsp_deliver = (state == ST_WAIT) & bus.imem_rsp_valid & ~take;
  assign hb_load     = rsp_deliver & ~bus.if_ready;
  assign hb_clear    = (state == ST_HOLD) & (take | bus.if_ready);

  fetch_hold_buf #(.XLEN(XLEN)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (hb_load),
    .clear    (hb_clear),
    .pc_in    (pc_q),
    .instr_in (bus.imem_rsp_data),
    .valid    (hb_valid),
    .pc       (hb_pc),
    .instr    (hb_instr)
  );

  assign bus.imem_req_valid = (state == ST_REQ);
  assign bus.imem_req_addr  = pc_q;
  // WAIT forwards the response straight through; HOLD replays the capture.
  assign bus.if_valid       = rsp_deliver | ((state == ST_HOLD) & hb_valid);
  assign bus.if_pc          = rsp_deliver ? pc_q : hb_pc;
  assign bus.if_instr       = rsp_deliver ? bus.imem_rsp_data : hb_instr;
  assign current_pc         = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc_q  <= RESET_VECTOR;
    end else begin
      unique case (state)
        ST_BOOT: begin
          if (take) pc_q <= tgt;
          state <= ST_REQ;
        end
        ST_REQ: begin
          if (take) begin
            pc_q <= tgt;
            // an accepted request is now stale; its response must be drained
            if (bus.imem_req_ready) state <= ST_FLUSH;
          end else if (bus.imem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (take) begin
            pc_q  <= tgt;
            state <= bus.imem_rsp_valid ? ST_REQ : ST_FLUSH;
          end else if (bus.imem_rsp_valid) begin
            if (bus.if_ready) begin
              pc_q  <= pc_q + STEP;
              state <= ST_REQ;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (take) begin
            pc_q  <= tgt;
            state <= ST_REQ;
          end else if (bus.if_ready) begin
            pc_q  <= pc_q + STEP;
            state <= ST_REQ;
          end
        end
        ST_FLUSH: begin
          if (take) pc_q <= tgt;
          if (bus.imem_rsp_valid) state <= ST_REQ;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized run against a
// transaction-level PC model (pc = last taken target + 4 per delivered
// instruction). A memory responder with configurable ready/latency returns
// mem_word(addr) for every accepted request.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vector = '0;
  logic [31:0] current_pc;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.XLEN(32)) bus();

  fetch_sequencer #(
    .XLEN(32), .RESET_VECTOR(32'h8000_0000), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .bus(bus), .current_pc(current_pc), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 ^ ((a - 32'h8000_0000) * 32'h0001_0001);
  endfunction

  // memory responder, updates on negedge
  logic        mem_rand_ready = 1'b0;
  int          mem_lat_min = 1;
  int          mem_lat_max = 1;
  logic        mem_pending = 1'b0;

  initial begin
    logic        acc_prev;
    logic [31:0] acc_addr;
    logic [31:0] paddr;
    int          wcnt;
    acc_prev = 1'b0; acc_addr = '0; paddr = '0; wcnt = 0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.if_ready       = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        acc_prev = 1'b0; mem_pending = 1'b0; wcnt = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
      end else begin
        if (acc_prev) begin
          mem_pending = 1'b1;
          paddr = acc_addr;
          wcnt = int'($urandom_range(mem_lat_max, mem_lat_min)) - 1;
        end
        bus.imem_rsp_valid = 1'b0;
        if (mem_pending) begin
          if (wcnt == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(paddr);
            mem_pending = 1'b0;
          end else begin
            wcnt = wcnt - 1;
          end
        end
        bus.imem_req_ready = mem_rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
        acc_prev = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
      end
    end
  end

  // leaves the bench at the BOOT cycle, #1 after reset release
  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0; trap_valid = 1'b0;
    bus.if_ready = 1'b1;
    mem_rand_ready = 1'b0; mem_lat_min = 1; mem_lat_max = 1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.imem_req_valid && bus.imem_req_ready) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_deliver(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.if_valid && bus.if_ready) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b exp=0", bus.if_valid); end
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    checks++; if (bus.if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h exp=0", bus.if_instr); end
    checks++; if (current_pc !== 32'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=80000000", current_pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] addrs[$];
    int first_req;
    first_req = -1;
    do_reset();
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL boot_no_req got=%b exp=0", bus.imem_req_valid); end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (bus.imem_req_valid && first_req < 0) first_req = c;
      if (bus.imem_req_valid && bus.imem_req_ready) addrs.push_back(bus.imem_req_addr);
    end
    checks++; if (first_req != 0) begin failures++; $display("FAIL seq_first_req_cycle got=%0d exp=0", first_req); end
    checks++; if (addrs.size() != 7) begin failures++; $display("FAIL seq_throughput got=%0d exp=7", addrs.size()); end
    for (int i = 0; i < 3 && i < addrs.size(); i++) begin
      checks++;
      if (addrs[i] !== 32'h8000_0000 + 32'(4 * i)) begin
        failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, addrs[i], 32'h8000_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    bus.if_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); #1;
      ok = bus.if_valid;
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_first_valid got=0 exp=1"); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (bus.if_valid !== 1'b1 || bus.if_instr !== 32'h13 || bus.if_pc !== 32'h8000_0000) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/00000013/80000000", k, bus.if_valid, bus.if_instr, bus.if_pc);
      end
      checks++; if (bus.imem_req_valid !== 1'b0 || current_pc !== 32'h8000_0000) begin
        failures++; $display("FAIL bp_stall%0d got=%b/%h exp=0/80000000", k, bus.imem_req_valid, current_pc);
      end
    end
    @(negedge clk); bus.if_ready = 1'b1; #1;
    checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", bus.if_valid); end
    @(negedge clk); #1;
    checks++; if (current_pc !== 32'h8000_0004 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0004) begin
      failures++; $display("FAIL bp_advance got=%h/%b/%h exp=80000004/1/80000004", current_pc, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    mem_lat_min = 2; mem_lat_max = 2;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rw_req_timeout got=0 exp=1"); end
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++; if (current_pc !== 32'h8000_0100) begin failures++; $display("FAIL rw_pc got=%h exp=80000100", current_pc); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rw_stale_dropped got=%b exp=0", bus.if_valid); end
    @(negedge clk); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
      failures++; $display("FAIL rw_next_req got=%b/%h exp=1/80000100", bus.imem_req_valid, bus.imem_req_addr);
    end
    wait_deliver(ok);
    checks++; if (!ok || bus.if_pc !== 32'h8000_0100 || bus.if_instr !== mem_word(32'h8000_0100)) begin
      failures++; $display("FAIL rw_deliver got=%b/%h/%h exp=1/80000100/%h", ok, bus.if_pc, bus.if_instr, mem_word(32'h8000_0100));
    end
  endtask

  task automatic test_trap_priority();
    bit ok;
    do_reset();
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL tp_req_timeout got=0 exp=1"); end
    @(negedge clk);
    trap_valid = 1'b1; trap_vector = 32'h8000_0040;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL tp_rsp_dropped got=%b exp=0", bus.if_valid); end
    @(negedge clk); trap_valid = 1'b0; redirect_valid = 1'b0; #1;
    checks++; if (current_pc !== 32'h8000_0040 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0040) begin
      failures++; $display("FAIL tp_target got=%h/%b/%h exp=80000040/1/80000040", current_pc, bus.imem_req_valid, bus.imem_req_addr);
    end
    wait_deliver(ok);
    checks++; if (!ok || bus.if_instr !== mem_word(32'h8000_0040)) begin
      failures++; $display("FAIL tp_deliver got=%b/%h exp=1/%h", ok, bus.if_instr, mem_word(32'h8000_0040));
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    wait_req(ok);
    @(negedge clk); #1;
    checks++; if (!ok || bus.if_valid !== 1'b1) begin failures++; $display("FAIL ar_in_wait got=%b/%b exp=1/1", ok, bus.if_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0 || bus.if_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++; $display("FAIL ar_ctrl got=%b/%b/%b exp=0/0/0", bus.imem_req_valid, bus.if_valid, fetch_fault);
    end
    checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0 || current_pc !== 32'h8000_0000) begin
      failures++; $display("FAIL ar_data got=%h/%h/%h exp=0/0/80000000", bus.if_pc, bus.if_instr, current_pc);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    wait_req(ok);
    checks++; if (!ok || bus.imem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL ar_restart got=%b/%h exp=1/80000000", ok, bus.imem_req_addr); end
    wait_deliver(ok);
    checks++; if (!ok || bus.if_instr !== 32'h13) begin failures++; $display("FAIL ar_deliver got=%b/%h exp=1/00000013", ok, bus.if_instr); end
  endtask

  task automatic test_misalign();
    bit ok;
    do_reset();
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ma_req_timeout got=0 exp=1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    @(negedge clk); redirect_valid = 1'b0; #1;
`ifdef FETCH_SEQ_MISALIGN_CHECK_EN
    checks++; if (fetch_fault !== 1'b1 || current_pc !== 32'h8000_0000) begin
      failures++; $display("FAIL ma_refused got=%b/%h exp=1/80000000", fetch_fault, current_pc);
    end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8000_0000) begin
      failures++; $display("FAIL ma_flow got=%b/%h exp=1/80000000", bus.if_valid, bus.if_pc);
    end
    @(negedge clk); #1;
    checks++; if (fetch_fault !== 1'b0 || current_pc !== 32'h8000_0004) begin
      failures++; $display("FAIL ma_pulse_end got=%b/%h exp=0/80000004", fetch_fault, current_pc);
    end
`else
    checks++; if (fetch_fault !== 1'b0 || current_pc !== 32'h8000_0100) begin
      failures++; $display("FAIL ma_aligned got=%b/%h exp=0/80000100", fetch_fault, current_pc);
    end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL ma_flush got=%b exp=0", bus.if_valid); end
    @(negedge clk); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0100) begin
      failures++; $display("FAIL ma_next_req got=%b/%h exp=1/80000100", bus.imem_req_valid, bus.imem_req_addr);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    wait_req(ok);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 1'b0; #1;
    wait_deliver(ok);
    checks++; if (!ok || bus.if_pc !== 32'hFFFF_FFFC || bus.if_instr !== mem_word(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_deliver got=%b/%h/%h exp=1/fffffffc/%h", ok, bus.if_pc, bus.if_instr, mem_word(32'hFFFF_FFFC));
    end
    @(negedge clk); #1;
    checks++; if (current_pc !== 32'h0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_pc got=%h/%b/%h exp=0/1/0", current_pc, bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    logic        fault_exp, take;
    int          deliveries, bad;
    int          r;
    do_reset();
    mem_rand_ready = 1'b1; mem_lat_min = 1; mem_lat_max = 3;
    exp_pc = 32'h8000_0000; fault_exp = 1'b0; deliveries = 0; bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      bus.if_ready   = ($urandom_range(3, 0) != 0);
      r              = int'($urandom_range(99, 0));
      redirect_valid = (r < 5);
      trap_valid     = (r >= 3 && r < 7);
      redirect_pc    = 32'h8000_0000 + 32'($urandom_range(1023, 0));
      trap_vector    = 32'h8000_1000 + 32'($urandom_range(1023, 0));
      #1;
      // checks report only the first few mismatches to keep output short
      checks++; if (current_pc !== exp_pc) begin failures++; if (bad++ < 5) $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, current_pc, exp_pc); end
      checks++; if (fetch_fault !== fault_exp) begin failures++; if (bad++ < 5) $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, fetch_fault, fault_exp); end
      if (bus.imem_req_valid) begin
        checks++; if (bus.imem_req_addr !== exp_pc || mem_pending) begin
          failures++; if (bad++ < 5) $display("FAIL rnd_req c=%0d got=%h/%b exp=%h/0", c, bus.imem_req_addr, mem_pending, exp_pc);
        end
      end
      if (bus.if_valid && bus.if_ready) begin
        checks++; if (bus.if_pc !== exp_pc || bus.if_instr !== mem_word(exp_pc)) begin
          failures++; if (bad++ < 5) $display("FAIL rnd_deliver c=%0d got=%h/%h exp=%h/%h", c, bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc));
        end
        deliveries++;
      end
      tgt  = trap_valid ? trap_vector : redirect_pc;
      take = redirect_valid || trap_valid;
`ifdef FETCH_SEQ_MISALIGN_CHECK_EN
      fault_exp = take && (tgt[1:0] != 2'b00);
      if (fault_exp) take = 1'b0;
`else
      tgt[1:0] = 2'b00;
`endif
      if (take) exp_pc = tgt;
      else if (bus.if_valid && bus.if_ready) exp_pc = exp_pc + 32'd4;
    end
    redirect_valid = 1'b0; trap_valid = 1'b0; bus.if_ready = 1'b1;
    checks++; if (deliveries < 100) begin failures++; $display("FAIL rnd_liveness got=%0d exp>=100", deliveries); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_trap_priority();
    test_async_reset();
    test_misalign();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
